// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//   Shared definitions for the tick generator and its users.
//   - TICK_DIV_W / TICK_CNT_W : default widths of the period register and
//     the tick/burst counters, reused by the Life top level.
//   - tick_state_t            : controller state encoding.
package tick_gen_pkg;

    localparam int TICK_DIV_W = 24;
    localparam int TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BURST = 2'd3
    } tick_state_t;

endpackage

// File: rtl/tick_div_counter.sv
// tick_div_counter
//   Reloadable down-counter that measures one tick period.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : force the count to zero (highest priority)
//     load       : load load_val
//     load_val   : reload value (period minus one)
//     dec        : decrement by one when the count is non-zero
//     count      : current count
//     zero       : count == 0
module tick_div_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tick_gen.sv
// tick_gen
//   Runtime-programmable generator of single-cycle clock-enable pulses.
//   Modes: free running (run), single tick (step) and counted burst
//   (burst_start/burst_len). All outputs are registered.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     run         : level, free-running ticks while high
//     step        : pulse, request one tick
//     burst_start : pulse, request burst_len ticks
//     burst_len   : burst length, sampled with burst_start
//     div_load    : pulse, load div_value as the new period
//     div_value   : new period (0 behaves as 1)
//     tick        : one-cycle enable pulse
//     sq          : toggles on every tick
//     tick_count  : ticks since reset, wrapping
//     busy        : controller is not idle
//     done        : pulses with the final tick of a step or burst
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV_W       = TICK_DIV_W,
    parameter int CNT_W       = TICK_CNT_W,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             tick,
    output logic             sq,
    output logic [CNT_W-1:0] tick_count,
    output logic             busy,
    output logic             done
);

    // Handshake note: there is no valid/ready flow here; run is a level,
    // step/burst_start/div_load are single-cycle requests sampled on the
    // rising edge, and burst_start is only honoured while idle.

    function automatic logic [DIV_W-1:0] period_m1(input logic [DIV_W-1:0] v);
        // A zero period is treated as one, so its reload value is zero.
        return (v == '0) ? '0 : v - DIV_W'(1);
    endfunction

    tick_state_t      state, state_next;
    logic [DIV_W-1:0] div_reg;
    logic [CNT_W-1:0] remaining;

    logic             cnt_clear, cnt_load, cnt_dec, cnt_zero;
    logic [DIV_W-1:0] cnt_val, cnt_q;
    logic             rem_load, rem_dec;
    logic             tick_d, done_d;

    // Reload value for a phase start; a period written this cycle takes
    // effect immediately.
    logic [DIV_W-1:0] start_m1;
    assign start_m1 = div_load ? period_m1(div_value) : period_m1(div_reg);

    tick_div_counter #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_q),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = start_m1;
        cnt_dec    = 1'b0;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                    cnt_load   = 1'b1;
                end else if (burst_start) begin
                    // A zero-length burst is swallowed without any effect.
                    if (burst_len != '0) begin
                        state_next = BURST;
                        rem_load   = 1'b1;
                        cnt_load   = 1'b1;
                    end
                end else if (step) begin
                    state_next = STEP;
                    cnt_load   = 1'b1;
                end
            end

            RUN: begin
                if (!run) begin
                    // Stopping wins over everything, including a tick due now.
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end else if (div_load) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    tick_d   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            STEP: begin
                if (div_load) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    tick_d     = 1'b1;
                    done_d     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            BURST: begin
                if (div_load) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    tick_d   = 1'b1;
                    rem_dec  = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        done_d     = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_reg    <= DIV_W'(DEFAULT_DIV);
            remaining  <= '0;
            tick       <= 1'b0;
            sq         <= 1'b0;
            tick_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            tick  <= tick_d;
            done  <= done_d;
            if (div_load) begin
                div_reg <= div_value;
            end
            if (rem_load) begin
                remaining <= burst_len;
            end else if (rem_dec) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (tick_d) begin
                sq         <= ~sq;
                tick_count <= tick_count + CNT_W'(1);
            end
        end
    end

endmodule
